// File: rtl/csa_sbox_bank.sv
`default_nettype none
// ============================================================================
// Module   : csa_sbox_bank
// Brief    : Loadable bank of NBOX IN_W->OUT_W S-boxes for the CSA datapath,
//            served through a PIPE-deep valid/ready lookup pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module csa_sbox_bank #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 2,
    parameter int NBOX  = 7,
    parameter int PIPE  = 1,
    localparam int c_BOX_W = (NBOX > 1) ? $clog2(NBOX) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [c_BOX_W-1:0]      cfg_box,
    input  logic [IN_W-1:0]         cfg_addr,
    input  logic [OUT_W-1:0]        cfg_data,
    input  logic                    cfg_lock,
    input  logic                    cfg_unlock,
    output logic                    cfg_err,
    output logic                    active,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NBOX*IN_W-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NBOX*OUT_W-1:0]   out_data
);

    localparam int c_DEPTH = 2 ** IN_W;
    localparam int c_NENT  = NBOX * c_DEPTH;
    localparam int c_IDX_W = c_BOX_W + IN_W;
    localparam logic [c_BOX_W:0] c_NBOX_V = (c_BOX_W + 1)'(NBOX);

    localparam logic [1:0] c_ST_LOADING = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN   = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   r_err;
    logic                   w_err;
    logic                   w_loading;
    logic                   w_serving;

    logic [OUT_W-1:0]       r_table [c_NENT];
    logic [c_NENT-1:0]      r_written;
    logic [c_NENT-1:0]      w_wr_mask;
    logic [c_IDX_W-1:0]     w_wr_idx;
    logic                   w_box_ok;
    logic                   w_wr_en;
    logic                   w_all_written;

    logic [PIPE-1:0]        r_vld;
    logic [NBOX*OUT_W-1:0]  r_dat [PIPE];
    logic [PIPE-1:0]        w_open;
    logic                   w_accept;
    logic [NBOX*OUT_W-1:0]  w_lookup;

    // Config decode: the lock check sees a same-cycle write as already landed
    assign w_box_ok      = ({1'b0, cfg_box} < c_NBOX_V);
    assign w_wr_idx      = {cfg_box, cfg_addr};
    assign w_wr_en       = w_loading & cfg_we & w_box_ok;
    assign w_wr_mask     = w_wr_en ? (c_NENT'(1) << w_wr_idx) : '0;
    assign w_all_written = &(r_written | w_wr_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_LOADING;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_LOADING: if (cfg_lock && w_all_written) w_state_next = c_ST_ACTIVE;
            c_ST_ACTIVE:  if (cfg_unlock) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN:   if (r_vld == '0) w_state_next = c_ST_LOADING;
            default:      w_state_next = c_ST_LOADING;
        endcase
    end

    always_comb begin
        w_loading = 1'b0;
        w_serving = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            c_ST_LOADING: begin
                w_loading = 1'b1;
                w_err     = (cfg_we & ~w_box_ok) | (cfg_lock & ~w_all_written);
            end
            c_ST_ACTIVE: begin
                w_serving = 1'b1;
                w_err     = cfg_we | cfg_lock;
            end
            default: begin
                w_err     = cfg_we | cfg_lock;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_written <= '0;
        end else begin
            r_err     <= w_err;
            r_written <= r_written | w_wr_mask;
        end
    end

    // Table storage is deliberately not reset; the written-flags gate locking
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_table[w_wr_idx] <= cfg_data;
        end
    end

    for (genvar k = 0; k < NBOX; k++) begin : g_box
        localparam logic [c_BOX_W-1:0] c_K = c_BOX_W'(k);
        assign w_lookup[k*OUT_W +: OUT_W] = r_table[{c_K, in_data[k*IN_W +: IN_W]}];
    end

    // A stage can take new content when it is empty or its content moves on
    always_comb begin
        w_open[PIPE-1] = ~r_vld[PIPE-1] | out_ready;
        for (int i = PIPE - 2; i >= 0; i--) begin
            w_open[i] = ~r_vld[i] | w_open[i+1];
        end
    end

    assign in_ready = w_serving & w_open[0];
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            if (w_open[0]) begin
                r_vld[0] <= w_accept;
                if (w_accept) begin
                    r_dat[0] <= w_lookup;
                end
            end
            for (int i = 1; i < PIPE; i++) begin
                if (w_open[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end
        end
    end

    assign cfg_err   = r_err;
    assign active    = (r_state == c_ST_ACTIVE);
    assign out_valid = r_vld[PIPE-1];
    assign out_data  = r_dat[PIPE-1];

endmodule
`default_nettype wire

// File: tb/tb_csa_sbox_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_sbox_bank
// Brief    : Directed + random checks of csa_sbox_bank at PIPE=1 and PIPE=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_sbox_bank;
    localparam int IN_W  = 5;
    localparam int OUT_W = 2;
    localparam int NBOX  = 7;
    localparam int BOX_W = 3;
    localparam int DEPTH = 32;
    localparam int DW    = NBOX * IN_W;
    localparam int OW    = NBOX * OUT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst        [2];
    logic             cfg_we     [2];
    logic [BOX_W-1:0] cfg_box    [2];
    logic [IN_W-1:0]  cfg_addr   [2];
    logic [OUT_W-1:0] cfg_data   [2];
    logic             cfg_lock   [2];
    logic             cfg_unlock [2];
    logic             cfg_err    [2];
    logic             active     [2];
    logic             in_valid   [2];
    logic             in_ready   [2];
    logic [DW-1:0]    in_data    [2];
    logic             out_valid  [2];
    logic             out_ready  [2];
    logic [OW-1:0]    out_data   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        csa_sbox_bank #(.IN_W(IN_W), .OUT_W(OUT_W), .NBOX(NBOX), .PIPE(g + 1)) u_dut (
            .clk(clk), .rst(rst[g]), .cfg_we(cfg_we[g]), .cfg_box(cfg_box[g]),
            .cfg_addr(cfg_addr[g]), .cfg_data(cfg_data[g]), .cfg_lock(cfg_lock[g]),
            .cfg_unlock(cfg_unlock[g]), .cfg_err(cfg_err[g]), .active(active[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g])
        );
    end

    int errors = 0;
    int checks = 0;
    int d;
    int pipe_n;
    int tab [NBOX][DEPTH];
    int box0 [DEPTH] = '{3,1,2,3,0,2,1,2,1,2,0,1,3,0,0,3,1,0,3,1,2,3,0,3,0,3,2,0,1,2,2,1};
    logic [OW-1:0] q [$];
    bit            held_v;
    logic [OW-1:0] held;
    int            received;
    bit            saw_block;

    function automatic logic [OW-1:0] model(input logic [DW-1:0] din);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < NBOX; k++) begin
            r[k*OUT_W +: OUT_W] = OUT_W'(tab[k][din[k*IN_W +: IN_W]]);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_in();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s pipe=%0d observed=%0h expected=%0h", tag, pipe_n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle with scoreboard bookkeeping
    task automatic cyc(output bit acc);
        logic [OW-1:0] e;
        #1;
        if (held_v) begin
            chk("stall_valid", out_valid[d], 1);
            chk("stall_hold", out_data[d], held);
        end
        held_v = out_valid[d] && !out_ready[d];
        held   = out_data[d];
        acc    = in_valid[d] && in_ready[d];
        if (acc) q.push_back(model(in_data[d]));
        if (in_valid[d] && !in_ready[d]) saw_block = 1;
        if (out_valid[d] && out_ready[d]) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid[d], 0);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data[d], e);
                received++;
            end
        end
        tick();
    endtask

    task automatic clear_inputs();
        cfg_we[d] = 0; cfg_box[d] = '0; cfg_addr[d] = '0; cfg_data[d] = '0;
        cfg_lock[d] = 0; cfg_unlock[d] = 0; in_valid[d] = 0; in_data[d] = '0;
        out_ready[d] = 0;
    endtask

    task automatic wr(input int box, input int addr, input int data, input bit upd);
        cfg_we[d] = 1; cfg_box[d] = BOX_W'(box); cfg_addr[d] = IN_W'(addr);
        cfg_data[d] = OUT_W'(data);
        tick();
        cfg_we[d] = 0;
        if (upd) tab[box][addr] = data;
    endtask

    task automatic load_all(input bit skip_last, input bit rnd);
        for (int b = 0; b < NBOX; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (!(skip_last && b == NBOX - 1 && a == DEPTH - 1)) begin
                    if (rnd) wr(b, a, int'($urandom_range(0, 3)), 1);
                    else     wr(b, a, (b == 0) ? box0[a] : (a & 3), 1);
                end
            end
        end
    endtask

    task automatic lock_try(input bit exp_active, input bit exp_err);
        cfg_lock[d] = 1;
        tick();
        cfg_lock[d] = 0;
        chk("lock_active", active[d], exp_active);
        chk("lock_err", cfg_err[d], exp_err);
        tick();
        chk("err_pulse_end", cfg_err[d], 0);
    endtask

    task automatic single_lookup(input logic [IN_W-1:0] v, input logic [OUT_W-1:0] exp0);
        logic [DW-1:0] din;
        int n;
        din = rnd_in();
        din[IN_W-1:0] = v;
        in_data[d] = din; in_valid[d] = 1; out_ready[d] = 1;
        #1;
        chk("lookup_in_ready", in_ready[d], 1);
        tick();
        in_valid[d] = 0;
        n = 1;
        while (!out_valid[d] && n < 8) begin
            tick();
            n++;
        end
        chk("latency", n, pipe_n);
        chk("box0_value", out_data[d][OUT_W-1:0], exp0);
        chk("lookup_all", out_data[d], model(din));
        tick();
        chk("lookup_drained", out_valid[d], 0);
    endtask

    task automatic stream(input int num);
        int sent;
        bit acc;
        sent = 0; received = 0; saw_block = 0; held_v = 0; q.delete();
        in_data[d] = rnd_in(); in_valid[d] = 1;
        for (int c = 0; c < 400 && received < num; c++) begin
            out_ready[d] = (c % 3 == 0);
            cyc(acc);
            if (acc) begin
                sent++;
                if (sent == num) in_valid[d] = 0;
                else in_data[d] = rnd_in();
            end
        end
        in_valid[d] = 0; out_ready[d] = 1;
        chk("stream_count", received, num);
        chk("stream_leftover", q.size(), 0);
        chk("stream_backpressure", saw_block, 1);
    endtask

    task automatic run(input int dd);
        bit acc;
        int n;
        d = dd; pipe_n = dd + 1;
        clear_inputs();
        rst[d] = 1; tick(); tick(); rst[d] = 0;
        q.delete(); held_v = 0;
        chk("rst_err", cfg_err[d], 0);
        chk("rst_active", active[d], 0);
        chk("rst_in_ready", in_ready[d], 0);
        chk("rst_out_valid", out_valid[d], 0);
        chk("rst_out_data", out_data[d], 0);

        // Load with one entry missing, then complete and lock
        load_all(1, 0);
        lock_try(0, 1);
        wr(NBOX - 1, DEPTH - 1, 3, 1);
        lock_try(1, 0);
        single_lookup(5'h00, 2'h3);
        single_lookup(5'h1f, 2'h1);
        single_lookup(5'h0c, 2'h3);

        stream(20);

        // Unlock in the cycle of the third accept
        q.delete(); received = 0; held_v = 0; out_ready[d] = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid[d] = 1; in_data[d] = rnd_in(); cfg_unlock[d] = (i == 2);
            cyc(acc);
            chk("unlock_accept", acc, 1);
        end
        cfg_unlock[d] = 0; in_data[d] = rnd_in();
        #1;
        chk("drain_in_ready", in_ready[d], 0);
        chk("drain_active", active[d], 0);
        for (int c = 0; c < 20 && received < 3; c++) begin
            cyc(acc);
            chk("drain_no_accept", acc, 0);
        end
        in_valid[d] = 0;
        chk("drain_delivered", received, 3);
        tick(); tick();
        lock_try(1, 0);

        // Illegal config actions leave tables intact
        wr(0, 0, 0, 0);
        chk("we_active_err", cfg_err[d], 1);
        lock_try(1, 1);
        cfg_unlock[d] = 1; tick(); cfg_unlock[d] = 0; tick(); tick();
        chk("unlocked", active[d], 0);
        wr(7, 0, 0, 0);
        chk("bad_box_err", cfg_err[d], 1);
        tick();
        chk("bad_box_err_end", cfg_err[d], 0);
        lock_try(1, 0);
        single_lookup(5'h00, 2'h3);
        single_lookup(5'h1f, 2'h1);

        // Reset while a result is pending
        out_ready[d] = 0; in_valid[d] = 1; in_data[d] = rnd_in();
        tick();
        in_valid[d] = 0;
        n = 0;
        while (!out_valid[d] && n < 8) begin
            tick();
            n++;
        end
        chk("pending_valid", out_valid[d], 1);
        rst[d] = 1; tick(); rst[d] = 0;
        q.delete(); held_v = 0;
        chk("midrst_out_valid", out_valid[d], 0);
        chk("midrst_active", active[d], 0);
        chk("midrst_in_ready", in_ready[d], 0);
        lock_try(0, 1);
        load_all(1, 1);
        lock_try(0, 1);
        wr(NBOX - 1, DEPTH - 1, int'($urandom_range(0, 3)), 1);
        lock_try(1, 0);
        stream(12);
        clear_inputs();
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            d = g;
            rst[g] = 0;
            clear_inputs();
        end
        tick();
        run(0);
        run(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
